// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between two masters.
// A per-transfer timeout completes hung accesses with TO_DATA and pulses to_err.
module mem_bus_arbiter #(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter int unsigned   TO_CYCLES = 1024,
  parameter logic [DW-1:0] TO_DATA   = '1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_dout,
  output logic [DW-1:0]   m0_din,
  input  logic            m0_wr,
  input  logic [DW/8-1:0] m0_lane,
  input  logic            m0_valid,
  output logic            m0_ready,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_dout,
  output logic [DW-1:0]   m1_din,
  input  logic            m1_wr,
  input  logic [DW/8-1:0] m1_lane,
  input  logic            m1_valid,
  output logic            m1_ready,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_dout,
  input  logic [DW-1:0]   s_din,
  output logic            s_wr,
  output logic [DW/8-1:0] s_lane,
  output logic            s_valid,
  input  logic            s_ready,
  output logic [1:0]      grant,
  output logic            to_err
);
  localparam int unsigned   CW      = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state;
  logic          r_owner;
  logic          r_last;
  logic [CW-1:0] r_to_cnt;

  logic w_busy, w_sel, w_own_valid, w_timeout, w_done, w_pick;

  always_comb begin
    w_busy      = (r_state == S_BUSY);
    w_sel       = w_busy & r_owner;
    w_own_valid = r_owner ? m1_valid : m0_valid;
    w_timeout   = w_busy & (r_to_cnt == TO_LAST);
    // An owner that dropped valid gets no ready, even on the timeout cycle.
    w_done      = w_busy & w_own_valid & (s_ready | w_timeout);
    w_pick      = (m0_valid & m1_valid) ? ~r_last : m1_valid;
  end

  always_comb begin
    s_addr   = w_sel ? m1_addr : m0_addr;
    s_dout   = w_sel ? m1_dout : m0_dout;
    s_wr     = w_sel ? m1_wr   : m0_wr;
    s_lane   = w_sel ? m1_lane : m0_lane;
    s_valid  = w_busy & w_own_valid & ~w_timeout;
    m0_ready = w_done & ~r_owner;
    m1_ready = w_done & r_owner;
    m0_din   = w_timeout ? TO_DATA : s_din;
    m1_din   = w_timeout ? TO_DATA : s_din;
    grant    = w_busy ? {r_owner, ~r_owner} : 2'b00;
    to_err   = w_timeout & w_own_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_to_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_valid | m1_valid) begin
            r_state  <= S_BUSY;
            r_owner  <= w_pick;
            r_to_cnt <= '0;
          end
        end
        S_BUSY: begin
          if (w_done) begin
            r_state <= S_IDLE;
            r_last  <= r_owner;
          end else if (!w_own_valid) begin
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized masters/slave
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] ma[2];
  logic [31:0] md[2];
  logic        mw[2];
  logic [3:0]  ml[2];
  logic        mv[2];
  logic [31:0] m0_din, m1_din;
  logic        m0_ready, m1_ready;
  logic [31:0] s_addr, s_dout, s_din;
  logic        s_wr, s_valid, s_ready;
  logic [3:0]  s_lane;
  logic [1:0]  grant;
  logic        to_err;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(.AW(32), .DW(32), .TO_CYCLES(TO), .TO_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(ma[0]), .m0_dout(md[0]), .m0_din(m0_din), .m0_wr(mw[0]),
    .m0_lane(ml[0]), .m0_valid(mv[0]), .m0_ready(m0_ready),
    .m1_addr(ma[1]), .m1_dout(md[1]), .m1_din(m1_din), .m1_wr(mw[1]),
    .m1_lane(ml[1]), .m1_valid(mv[1]), .m1_ready(m1_ready),
    .s_addr(s_addr), .s_dout(s_dout), .s_din(s_din), .s_wr(s_wr),
    .s_lane(s_lane), .s_valid(s_valid), .s_ready(s_ready),
    .grant(grant), .to_err(to_err)
  );

  // Reference model: who owns the bus (if anyone), who was served last,
  // and how many cycles the current grant has waited for the slave.
  bit          md_busy;
  int          md_own;
  int          md_last;
  int unsigned md_age;

  logic [1:0]  e_grant;
  logic        e_sval, e_toerr;
  logic        e_rdy[2];
  logic [31:0] e_din, e_addr, e_dout;
  logic        e_wr;
  logic [3:0]  e_lane;

  task automatic model_reset();
    md_busy = 0; md_own = 0; md_last = 1; md_age = 0;
  endtask

  task automatic predict();
    int sel;
    bit ov, tmo;
    sel      = md_busy ? md_own : 0;
    ov       = md_busy && mv[md_own];
    tmo      = md_busy && (md_age == TO - 1);
    e_grant  = md_busy ? ((md_own == 1) ? 2'b10 : 2'b01) : 2'b00;
    e_addr   = ma[sel];
    e_dout   = md[sel];
    e_wr     = mw[sel];
    e_lane   = ml[sel];
    e_sval   = ov && !tmo;
    e_toerr  = ov && tmo;
    e_rdy[0] = ov && (md_own == 0) && (s_ready || tmo);
    e_rdy[1] = ov && (md_own == 1) && (s_ready || tmo);
    e_din    = tmo ? 32'hFFFF_FFFF : s_din;
  endtask

  task automatic model_edge();
    if (!rst_n) model_reset();
    else if (!md_busy) begin
      if (mv[0] || mv[1]) begin
        md_busy = 1;
        md_own  = (mv[0] && mv[1]) ? 1 - md_last : (mv[1] ? 1 : 0);
        md_age  = 0;
      end
    end else if (e_rdy[md_own]) begin
      md_busy = 0;
      md_last = md_own;
    end else if (!mv[md_own]) md_busy = 0;
    else md_age++;
  endtask

  task automatic tick();
    predict();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; ma[i] = '0; md[i] = '0; mw[i] = 0; ml[i] = '0;
    end
    s_ready = 0; s_din = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got=%b exp=0", s_valid); end
    checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", m0_ready, m1_ready); end
    checks++; if (to_err !== 1'b0) begin errors++; $display("FAIL reset_to_err got=%b exp=0", to_err); end
    tick();
  endtask

  task automatic test_single_read();
    int m1_seen = 0;
    mv[0] = 1; mw[0] = 0; ma[0] = 32'h100; ml[0] = 4'hF; s_ready = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc == 2) begin s_ready = 1; s_din = 32'hDEADBEEF; end
      if (cyc == 3) begin mv[0] = 0; s_ready = 0; end
      #1;
      checks++; if (s_valid !== (cyc == 1 || cyc == 2)) begin errors++; $display("FAIL rd_s_valid cyc=%0d got=%b", cyc, s_valid); end
      checks++; if (grant !== ((cyc == 1 || cyc == 2) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL rd_grant cyc=%0d got=%b", cyc, grant); end
      checks++; if (m0_ready !== (cyc == 2)) begin errors++; $display("FAIL rd_m0_ready cyc=%0d got=%b", cyc, m0_ready); end
      if (cyc == 1) begin
        checks++; if (s_addr !== 32'h100 || s_wr !== 1'b0) begin errors++; $display("FAIL rd_addr got=%h wr=%b exp=00000100 wr=0", s_addr, s_wr); end
      end
      if (cyc == 2) begin
        checks++; if (m0_din !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_din got=%h exp=deadbeef", m0_din); end
      end
      if (m1_ready !== 1'b0) m1_seen++;
      tick();
    end
    checks++; if (m1_seen != 0) begin errors++; $display("FAIL rd_m1_ready got=%0d cycles high exp=0", m1_seen); end
  endtask

  task automatic test_tie_break();
    logic [1:0] exp_g[5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    idle_inputs();
    rst_n = 0; tick(); rst_n = 1;
    mv[0] = 1; mv[1] = 1; ma[0] = 32'h10; ma[1] = 32'h20;
    for (int cyc = 0; cyc < 5; cyc++) begin
      s_ready = (cyc == 1 || cyc == 3);
      if (cyc == 2) mv[0] = 0;
      if (cyc == 4) mv[1] = 0;
      #1;
      checks++; if (grant !== exp_g[cyc]) begin errors++; $display("FAIL tie_grant cyc=%0d got=%b exp=%b", cyc, grant, exp_g[cyc]); end
      tick();
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g[4] = '{2'b00, 2'b01, 2'b00, 2'b10};
    logic prev_rdy[2] = '{1'b0, 1'b0};
    s_ready = 1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      for (int i = 0; i < 2; i++) mv[i] = (cyc < 8) && !prev_rdy[i];
      #1;
      if (cyc < 8) begin
        checks++; if (grant !== exp_g[cyc % 4]) begin errors++; $display("FAIL alt_grant cyc=%0d got=%b exp=%b", cyc, grant, exp_g[cyc % 4]); end
      end
      prev_rdy[0] = m0_ready; prev_rdy[1] = m1_ready;
      tick();
    end
    s_ready = 0;
  endtask

  task automatic test_timeout();
    mv[0] = 1; mw[0] = 0; ma[0] = 32'h300; s_ready = 0; s_din = 32'h12345678;
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (cyc == 17) mv[0] = 0;
      #1;
      checks++; if (m0_ready !== (cyc == 16) || to_err !== (cyc == 16)) begin errors++; $display("FAIL to_ready cyc=%0d got rdy=%b err=%b", cyc, m0_ready, to_err); end
      checks++; if (s_valid !== (cyc >= 1 && cyc <= 15)) begin errors++; $display("FAIL to_s_valid cyc=%0d got=%b", cyc, s_valid); end
      if (cyc == 16) begin
        checks++; if (m0_din !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_din got=%h exp=ffffffff", m0_din); end
      end
      if (cyc == 17) begin
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_idle got=%b exp=00", grant); end
      end
      tick();
    end
  endtask

  task automatic test_write_pass();
    mv[1] = 1; mw[1] = 1; ma[1] = 32'h2003; md[1] = 32'hABAB_ABAB; ml[1] = 4'b1000;
    for (int cyc = 0; cyc < 5; cyc++) begin
      s_ready = (cyc == 3);
      if (cyc == 4) mv[1] = 0;
      #1;
      if (cyc >= 1 && cyc <= 3) begin
        checks++;
        if (s_wr !== 1'b1 || s_lane !== 4'b1000 || s_addr !== 32'h2003 || s_dout !== 32'hABAB_ABAB || grant !== 2'b10) begin
          errors++; $display("FAIL wr_fields cyc=%0d got wr=%b lane=%b addr=%h dout=%h grant=%b", cyc, s_wr, s_lane, s_addr, s_dout, grant);
        end
      end
      checks++; if (m1_ready !== (cyc == 3)) begin errors++; $display("FAIL wr_m1_ready cyc=%0d got=%b", cyc, m1_ready); end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    mv[1] = 1; mw[1] = 0; ma[1] = 32'h400; s_ready = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      rst_n = (cyc != 1);
      if (cyc == 2) mv[0] = 1;
      s_ready = (cyc == 3);
      if (cyc == 4) begin mv[0] = 0; mv[1] = 0; end
      #1;
      if (cyc == 1) begin
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL mr_busy got=%b exp=10", grant); end
      end
      if (cyc == 2) begin
        checks++; if (s_valid !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL mr_abandon got valid=%b grant=%b exp 0/00", s_valid, grant); end
      end
      if (cyc == 3) begin
        checks++; if (grant !== 2'b01 || m0_ready !== 1'b1) begin errors++; $display("FAIL mr_regrant got grant=%b rdy=%b exp 01/1", grant, m0_ready); end
      end
      tick();
    end
    rst_n = 1;
  endtask

  task automatic test_random();
    logic was_rdy[2] = '{1'b0, 1'b0};
    int unsigned rmax;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (was_rdy[i]) mv[i] = 0;
        else if (mv[i]) begin
          if ($urandom_range(0, 63) == 0) mv[i] = 0;
        end else if ($urandom_range(0, 1) == 1) begin
          mv[i] = 1; ma[i] = $urandom; md[i] = $urandom; mw[i] = 1'($urandom); ml[i] = 4'($urandom);
        end
      end
      rmax = ((c / 100) % 2 == 1) ? 15 : 3;
      s_ready = ($urandom_range(0, rmax) == 0);
      s_din = $urandom;
      #1;
      predict();
      checks++; if (grant !== e_grant) begin errors++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, grant, e_grant); end
      checks++; if (s_valid !== e_sval) begin errors++; $display("FAIL rnd_s_valid c=%0d got=%b exp=%b", c, s_valid, e_sval); end
      checks++; if (m0_ready !== e_rdy[0]) begin errors++; $display("FAIL rnd_m0_ready c=%0d got=%b exp=%b", c, m0_ready, e_rdy[0]); end
      checks++; if (m1_ready !== e_rdy[1]) begin errors++; $display("FAIL rnd_m1_ready c=%0d got=%b exp=%b", c, m1_ready, e_rdy[1]); end
      checks++; if (to_err !== e_toerr) begin errors++; $display("FAIL rnd_to_err c=%0d got=%b exp=%b", c, to_err, e_toerr); end
      checks++; if (m0_din !== e_din || m1_din !== e_din) begin errors++; $display("FAIL rnd_din c=%0d got=%h/%h exp=%h", c, m0_din, m1_din, e_din); end
      checks++;
      if (s_addr !== e_addr || s_dout !== e_dout || s_wr !== e_wr || s_lane !== e_lane) begin
        errors++; $display("FAIL rnd_fields c=%0d got %h %h %b %b exp %h %h %b %b", c, s_addr, s_dout, s_wr, s_lane, e_addr, e_dout, e_wr, e_lane);
      end
      was_rdy[0] = e_rdy[0]; was_rdy[1] = e_rdy[1];
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_single_read();
    test_tie_break();
    test_alternate();
    test_timeout();
    test_write_pass();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
